// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with packet locking and a registered output stage.
// Channels are picked by round-robin (MODE=0) or by the sel input (MODE=1).
module rr_stream_mux #(
    parameter int unsigned N    = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned MODE = 0,
    parameter int unsigned SW   = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    output logic           out_last,
    output logic [SW-1:0]  out_chan,
    input  logic           out_ready
);

    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [SW-1:0] chan_q, chan_d;
    logic          lock_q, lock_d;
    logic [SW-1:0] lock_chan_q, lock_chan_d;
    logic [SW-1:0] rr_ptr_q, rr_ptr_d;

    logic          load_en;
    logic [SW-1:0] cand;
    logic          cand_vld;
    logic [W-1:0]  cand_data;
    logic          cand_valid;
    logic          cand_last;
    logic          grant;
    logic          xfer;

    assign load_en = !valid_q || out_ready;

    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        if (lock_q) begin
            cand     = lock_chan_q;
            cand_vld = 1'b1;
        end else if (MODE == 0) begin
            // Wrapped channels first, then channels at or above the pointer override them;
            // the descending scan leaves the lowest index of each group as the winner.
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i] && (SW'(i) < rr_ptr_q)) begin
                    cand     = SW'(i);
                    cand_vld = 1'b1;
                end
            end
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i] && (SW'(i) >= rr_ptr_q)) begin
                    cand     = SW'(i);
                    cand_vld = 1'b1;
                end
            end
        end else begin
            if (32'(sel) < N) begin
                cand     = sel;
                cand_vld = 1'b1;
            end
        end
    end

    always_comb begin
        cand_data  = '0;
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (SW'(i) == cand) begin
                cand_data  = in_data[i*W +: W];
                cand_valid = in_valid[i];
                cand_last  = in_last[i];
            end
        end
    end

    // Round-robin never readies an idle channel, even while locked onto it.
    assign grant = !rst && load_en && cand_vld && ((MODE != 0) || cand_valid);
    assign xfer  = grant && cand_valid;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = grant && (SW'(i) == cand);
        end
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        last_d      = last_q;
        chan_d      = chan_q;
        lock_d      = lock_q;
        lock_chan_d = lock_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            data_d  = cand_data;
            valid_d = 1'b1;
            last_d  = cand_last;
            chan_d  = cand;
            if (cand_last) begin
                lock_d   = 1'b0;
                rr_ptr_d = (cand == SW'(N - 1)) ? '0 : cand + 1'b1;
            end else begin
                lock_d      = 1'b1;
                lock_chan_d = cand;
            end
        end else if (load_en) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
            chan_q      <= '0;
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            data_q      <= data_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
            chan_q      <= chan_d;
            lock_q      <= lock_d;
            lock_chan_q <= lock_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_chan  = chan_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: one round-robin and one select-mode instance share the stimulus,
// checked every cycle against a packet-level model plus directed literal expectations.
module tb_rr_stream_mux;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [1:0]     sel;
    logic           out_ready;

    logic [N-1:0]   rdy [2];
    logic [W-1:0]   od  [2];
    logic           ov  [2];
    logic           ol  [2];
    logic [1:0]     oc  [2];

    int n_chk  = 0;
    int n_fail = 0;

    rr_stream_mux #(.N(N), .W(W), .MODE(0)) u_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy[0]), .sel(sel), .out_data(od[0]), .out_valid(ov[0]), .out_last(ol[0]),
        .out_chan(oc[0]), .out_ready(out_ready)
    );

    rr_stream_mux #(.N(N), .W(W), .MODE(1)) u_sel (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rdy[1]), .sel(sel), .out_data(od[1]), .out_valid(ov[1]), .out_last(ol[1]),
        .out_chan(oc[1]), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level model: owner is the channel holding an open packet (-1 if none).
    int  m_owner [2];
    int  m_ptr   [2];
    int  m_ov    [2];
    int  m_od    [2];
    int  m_ol    [2];
    int  m_oc    [2];
    int  g_chan  [2];
    bit  g_xfer  [2];
    bit  g_load  [2];
    bit  g_rst   = 1'b0;
    bit  started = 1'b0;

    always @(negedge clk) begin
        g_rst = rst;
        for (int m = 0; m < 2; m++) begin
            int c;
            int exp_rdy;
            bit load;
            load = (m_ov[m] == 0) || out_ready;
            c = -1;
            if (rst) begin
                c = -1;
            end else if (m_owner[m] >= 0) begin
                if (m == 1 || in_valid[m_owner[m]]) c = m_owner[m];
            end else if (m == 0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (in_valid[(m_ptr[m] + k) % N]) c = (m_ptr[m] + k) % N;
            end else begin
                c = (int'(sel) < N) ? int'(sel) : -1;
            end
            exp_rdy   = (load && c >= 0) ? (1 << c) : 0;
            g_chan[m] = c;
            g_load[m] = load;
            g_xfer[m] = 1'b0;
            if (load && c >= 0) g_xfer[m] = in_valid[c];
            if (started) begin
                chk(m ? "sel.out_valid" : "rr.out_valid", 32'(ov[m]), m_ov[m]);
                chk(m ? "sel.out_data"  : "rr.out_data",  32'(od[m]), m_od[m]);
                chk(m ? "sel.out_last"  : "rr.out_last",  32'(ol[m]), m_ol[m]);
                chk(m ? "sel.out_chan"  : "rr.out_chan",  32'(oc[m]), m_oc[m]);
                chk(m ? "sel.in_ready"  : "rr.in_ready",  32'(rdy[m]), exp_rdy);
            end
        end
    end

    always @(posedge clk) begin
        if (g_rst) begin
            started = 1'b1;
            for (int m = 0; m < 2; m++) begin
                m_owner[m] = -1;
                m_ptr[m]   = 0;
                m_ov[m]    = 0;
                m_od[m]    = 0;
                m_ol[m]    = 0;
                m_oc[m]    = 0;
            end
        end else if (started) begin
            for (int m = 0; m < 2; m++) begin
                if (g_xfer[m]) begin
                    int c;
                    c       = g_chan[m];
                    m_ov[m] = 1;
                    m_od[m] = int'(in_data[c*W +: W]);
                    m_ol[m] = int'(in_last[c]);
                    m_oc[m] = c;
                    if (in_last[c]) begin
                        m_owner[m] = -1;
                        m_ptr[m]   = (c + 1) % N;
                    end else begin
                        m_owner[m] = c;
                    end
                end else if (g_load[m]) begin
                    m_ov[m] = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_ch(input int i, input logic [7:0] d, input logic v, input logic l);
        in_data[i*W +: W] = d;
        in_valid[i]       = v;
        in_last[i]        = l;
    endtask

    task automatic all_single();
        for (int i = 0; i < N; i++) set_ch(i, 8'(8'hA0 + i), 1'b1, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        in_last   = '0;
        all_single();

        // Reset with every channel valid
        step();
        step();
        at_neg();
        chk("reset out_valid", 32'(ov[0]), 0);
        chk("reset in_ready", 32'(rdy[0]), 0);
        chk("reset out_chan", 32'(oc[0]), 0);
        chk("reset sel in_ready", 32'(rdy[1]), 0);
        step();
        rst = 1'b0;
        at_neg();
        chk("first grant ch0", 32'(rdy[0]), 32'b0001);

        // Round-robin over single-beat packets
        for (int k = 0; k < 5; k++) begin
            step();
            at_neg();
            chk("rr seq chan", 32'(oc[0]), k % 4);
            chk("rr seq data", 32'(od[0]), 32'h A0 + (k % 4));
            chk("rr seq valid", 32'(ov[0]), 1);
        end

        // Three-beat packet on ch2 with other channels valid
        step();
        set_ch(2, 8'hB0, 1'b1, 1'b0);
        at_neg();
        chk("pre-lock chan", 32'(oc[0]), 1);
        step();
        set_ch(2, 8'hB1, 1'b1, 1'b0);
        at_neg();
        chk("lock beat1 chan", 32'(oc[0]), 2);
        chk("lock beat1 data", 32'(od[0]), 32'hB0);
        chk("lock beat1 last", 32'(ol[0]), 0);
        step();
        set_ch(2, 8'hB2, 1'b1, 1'b1);
        at_neg();
        chk("lock beat2 chan", 32'(oc[0]), 2);
        chk("lock beat2 data", 32'(od[0]), 32'hB1);
        step();
        set_ch(2, 8'hA2, 1'b1, 1'b1);
        at_neg();
        chk("lock beat3 data", 32'(od[0]), 32'hB2);
        chk("lock beat3 last", 32'(ol[0]), 1);
        step();
        at_neg();
        chk("after lock chan", 32'(oc[0]), 3);
        step();
        out_ready = 1'b0;
        at_neg();
        chk("then ch0", 32'(oc[0]), 0);
        chk("backpressure ready", 32'(rdy[0]), 0);

        // Backpressure holds the output register
        for (int k = 0; k < 4; k++) begin
            step();
            at_neg();
            chk("bp hold data", 32'(od[0]), 32'hA0);
            chk("bp hold valid", 32'(ov[0]), 1);
            chk("bp ready", 32'(rdy[0]), 0);
        end
        step();
        out_ready = 1'b1;
        at_neg();
        chk("bp release ready", 32'(rdy[0]), 32'b0010);
        step();
        at_neg();
        chk("resume ch1", 32'(od[0]), 32'hA1);
        step();
        in_valid = 4'b0010;
        set_ch(1, 8'hC0, 1'b1, 1'b0);
        at_neg();
        chk("resume ch2", 32'(od[0]), 32'hA2);

        // Reset in the middle of a ch1 packet
        step();
        set_ch(1, 8'hC1, 1'b1, 1'b0);
        rst = 1'b1;
        at_neg();
        chk("mid pkt beat1", 32'(od[0]), 32'hC0);
        step();
        rst = 1'b0;
        in_valid = 4'b0011;
        at_neg();
        chk("mid rst valid", 32'(ov[0]), 0);
        chk("mid rst ready", 32'(rdy[0]), 32'b0001);
        step();
        at_neg();
        chk("mid rst first", 32'(od[0]), 32'hA0);

        // Select mode: lock on ch3 overrides a sel change
        step();
        rst = 1'b1;
        all_single();
        at_neg();
        step();
        rst = 1'b0;
        sel = 2'd3;
        set_ch(3, 8'hD0, 1'b1, 1'b0);
        at_neg();
        chk("sel3 ready", 32'(rdy[1]), 32'b1000);
        step();
        sel = 2'd1;
        set_ch(3, 8'hD1, 1'b1, 1'b1);
        at_neg();
        chk("sel beat1", 32'(od[1]), 32'hD0);
        chk("sel lock ready", 32'(rdy[1]), 32'b1000);
        step();
        set_ch(3, 8'hA3, 1'b1, 1'b1);
        at_neg();
        chk("sel beat2 chan", 32'(oc[1]), 3);
        chk("sel beat2 data", 32'(od[1]), 32'hD1);
        chk("sel ch1 ready", 32'(rdy[1]), 32'b0010);
        step();
        at_neg();
        chk("sel ch1 chan", 32'(oc[1]), 1);

        // Locked packet with a source gap
        step();
        rst = 1'b1;
        all_single();
        at_neg();
        step();
        rst = 1'b0;
        set_ch(0, 8'hE0, 1'b1, 1'b0);
        at_neg();
        step();
        set_ch(0, 8'hE0, 1'b0, 1'b0);
        at_neg();
        chk("gap beat1", 32'(od[0]), 32'hE0);
        chk("gap ready", 32'(rdy[0]), 0);
        step();
        at_neg();
        chk("gap drained", 32'(ov[0]), 0);
        chk("gap still locked", 32'(rdy[0]), 0);
        step();
        set_ch(0, 8'hE1, 1'b1, 1'b1);
        at_neg();
        chk("gap resume ready", 32'(rdy[0]), 32'b0001);
        step();
        at_neg();
        chk("gap beat2", 32'(od[0]), 32'hE1);

        // Mixed traffic checked by the model alone
        for (int k = 0; k < 300; k++) begin
            step();
            in_data   = 32'($urandom);
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(3) != 0);
            rst       = ($urandom_range(60) == 0);
        end
        step();
        rst = 1'b0;
        at_neg();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
